// File: rtl/fft_peak_search.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_peak_search                                                          |
// | Streaming L1-magnitude peak detector on the FFT's multi-lane output.     |
// | Optional: PEAK_SKIP_DC_EN suppresses bin 0 (DC) from the search.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft_peak_search #(
  parameter int LANES = 16,
  parameter int BEATS = 32,
  parameter int DW    = 13
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               din_valid,
  input  logic                               din_sof,
  input  logic [LANES-1:0][DW-1:0]           din_i,
  input  logic [LANES-1:0][DW-1:0]           din_q,
  output logic                               peak_valid,
  output logic [$clog2(LANES*BEATS)-1:0]     peak_bin,
  output logic [DW:0]                        peak_mag,
  output logic                               frame_abort
);

  localparam int c_bin_w  = $clog2(LANES*BEATS);
  localparam int c_lane_w = $clog2(LANES);
  localparam int c_cnt_w  = $clog2(BEATS);
  localparam int c_mag_w  = DW + 1;
  localparam int c_grp    = 4;
  localparam int c_gsz    = LANES / c_grp;

  // ---------------------------------------------------------------- framing
  logic [c_cnt_w-1:0] r_beat_cnt;
  logic [c_cnt_w-1:0] w_beat_cnt_nxt;
  logic [c_cnt_w-1:0] w_beat_idx;
  logic               w_first;
  logic               w_last;
  logic               w_abort;

  always_comb begin
    w_first        = din_sof || (r_beat_cnt == '0);
    w_last         = (r_beat_cnt == c_cnt_w'(BEATS-1)) && !din_sof;
    w_abort        = din_valid && din_sof && (r_beat_cnt != '0);
    w_beat_idx     = din_sof ? '0 : r_beat_cnt;
    w_beat_cnt_nxt = r_beat_cnt;
    if (din_valid) begin
      if (din_sof)
        w_beat_cnt_nxt = c_cnt_w'(1);
      else if (w_last)
        w_beat_cnt_nxt = '0;
      else
        w_beat_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat_cnt  <= '0;
      frame_abort <= 1'b0;
    end else begin
      r_beat_cnt  <= w_beat_cnt_nxt;
      frame_abort <= w_abort;
    end
  end

  // ---------------------------------------------------------------- S1: |I|+|Q|
  logic [LANES-1:0][c_mag_w-1:0] w_s1_mag;
  logic [LANES-1:0][c_mag_w-1:0] w_s1_mag_dc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] w_abs_i;
    logic [DW-1:0] w_abs_q;
    // Unsigned DW-bit negate keeps the most negative code (-2^(DW-1)) exact.
    assign w_abs_i     = din_i[l][DW-1] ? (DW'(0) - din_i[l]) : din_i[l];
    assign w_abs_q     = din_q[l][DW-1] ? (DW'(0) - din_q[l]) : din_q[l];
    assign w_s1_mag[l] = {1'b0, w_abs_i} + {1'b0, w_abs_q};
  end

`ifdef PEAK_SKIP_DC_EN
  always_comb begin
    w_s1_mag_dc = w_s1_mag;
    if (w_beat_idx == '0)
      w_s1_mag_dc[0] = '0;
  end
`else
  assign w_s1_mag_dc = w_s1_mag;
`endif

  logic                          r_s1_valid;
  logic                          r_s1_first;
  logic                          r_s1_last;
  logic [c_cnt_w-1:0]            r_s1_beat;
  logic [LANES-1:0][c_mag_w-1:0] r_s1_mag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_beat  <= '0;
      r_s1_mag   <= '0;
    end else begin
      r_s1_valid <= din_valid;
      r_s1_first <= din_valid && w_first;
      r_s1_last  <= din_valid && w_last;
      if (din_valid) begin
        r_s1_beat <= w_beat_idx;
        r_s1_mag  <= w_s1_mag_dc;
      end
    end
  end

  // ---------------------------------------------------------------- S2: lanes -> groups
  // Strict '>' while scanning upward means ties keep the lower lane.
  logic [c_grp-1:0][c_mag_w-1:0]  w_s2_mag;
  logic [c_grp-1:0][c_lane_w-1:0] w_s2_lane;

  always_comb begin
    w_s2_mag  = '0;
    w_s2_lane = '0;
    for (int g = 0; g < c_grp; g++) begin
      w_s2_mag[g]  = r_s1_mag[g*c_gsz];
      w_s2_lane[g] = c_lane_w'(g*c_gsz);
      for (int k = 1; k < c_gsz; k++) begin
        if (r_s1_mag[g*c_gsz+k] > w_s2_mag[g]) begin
          w_s2_mag[g]  = r_s1_mag[g*c_gsz+k];
          w_s2_lane[g] = c_lane_w'(g*c_gsz+k);
        end
      end
    end
  end

  logic                           r_s2_valid;
  logic                           r_s2_first;
  logic                           r_s2_last;
  logic [c_cnt_w-1:0]             r_s2_beat;
  logic [c_grp-1:0][c_mag_w-1:0]  r_s2_mag;
  logic [c_grp-1:0][c_lane_w-1:0] r_s2_lane;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_beat  <= '0;
      r_s2_mag   <= '0;
      r_s2_lane  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_s2_beat <= r_s1_beat;
        r_s2_mag  <= w_s2_mag;
        r_s2_lane <= w_s2_lane;
      end
    end
  end

  // ---------------------------------------------------------------- S3: groups -> beat max
  logic [c_mag_w-1:0]  w_s3_mag;
  logic [c_lane_w-1:0] w_s3_lane;

  always_comb begin
    w_s3_mag  = r_s2_mag[0];
    w_s3_lane = r_s2_lane[0];
    for (int g = 1; g < c_grp; g++) begin
      if (r_s2_mag[g] > w_s3_mag) begin
        w_s3_mag  = r_s2_mag[g];
        w_s3_lane = r_s2_lane[g];
      end
    end
  end

  logic                r_s3_valid;
  logic                r_s3_first;
  logic                r_s3_last;
  logic [c_cnt_w-1:0]  r_s3_beat;
  logic [c_mag_w-1:0]  r_s3_mag;
  logic [c_lane_w-1:0] r_s3_lane;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s3_valid <= 1'b0;
      r_s3_first <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_beat  <= '0;
      r_s3_mag   <= '0;
      r_s3_lane  <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_s3_first <= r_s2_first;
      r_s3_last  <= r_s2_last;
      if (r_s2_valid) begin
        r_s3_beat <= r_s2_beat;
        r_s3_mag  <= w_s3_mag;
        r_s3_lane <= w_s3_lane;
      end
    end
  end

  // ---------------------------------------------------------------- S4: frame accumulator
  logic [c_bin_w-1:0] w_s3_bin;
  logic [c_mag_w-1:0] r_acc_mag;
  logic [c_bin_w-1:0] r_acc_bin;
  logic               r_s4_last;

  assign w_s3_bin = c_bin_w'(r_s3_beat) * c_bin_w'(LANES) + c_bin_w'(r_s3_lane);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc_mag <= '0;
      r_acc_bin <= '0;
      r_s4_last <= 1'b0;
    end else begin
      r_s4_last <= r_s3_valid && r_s3_last;
      // A first beat reloads unconditionally, so stale beats of an aborted frame are dropped.
      if (r_s3_valid && (r_s3_first || (r_s3_mag > r_acc_mag))) begin
        r_acc_mag <= r_s3_mag;
        r_acc_bin <= w_s3_bin;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else begin
      peak_valid <= r_s4_last;
      if (r_s4_last) begin
        peak_bin <= r_acc_bin;
        peak_mag <= r_acc_mag;
      end
    end
  end

endmodule
`default_nettype wire
